// File: rtl/seven_seg_decoder.sv
// Receive-side seven-segment decoder: debounces the active-low display bus and
// recovers the signed digit value, flagging dash (out of range) and illegal patterns.
module seven_seg_decoder #(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned ERR_W         = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [6:0]       in_Seven,
    input  logic             in_neg,
    output logic [4:0]       out_Number,
    output logic             out_valid,
    output logic             out_range,
    output logic             out_error,
    output logic [ERR_W-1:0] out_errCount
);

    localparam int unsigned SAMP_W = 8;
    localparam int unsigned CNT_W  = 8;
    localparam logic [CNT_W-1:0] STABLE_MAX = CNT_W'(STABLE_CYCLES);
    localparam logic [6:0] PAT_BLANK = 7'b0000000;
    localparam logic [6:0] PAT_DASH  = 7'b1000000;

    typedef enum logic {SETTLE, LOCKED} state_t;
    typedef enum logic [1:0] {K_BLANK, K_LEGAL, K_DASH, K_ILLEGAL} kind_t;

    logic [SAMP_W-1:0] samp_c;
    logic [SAMP_W-1:0] samp_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              changed_c;
    state_t            state_q;
    state_t            state_d;
    logic              classify_c;
    logic [3:0]        mag_c;
    logic              hit_c;
    kind_t             kind_c;
    logic [4:0]        value_c;
    logic              have_last_q;

    // Active-high view of the bus: {neg, g..a}
    assign samp_c    = {~in_neg, ~in_Seven};
    assign changed_c = (samp_c != samp_q);

    // Sample register and stability counter (saturates at STABLE_MAX)
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            samp_q <= '0;
            cnt_q  <= CNT_W'(1);
        end else begin
            samp_q <= samp_c;
            if (changed_c) begin
                cnt_q <= CNT_W'(1);
            end else if (cnt_q < STABLE_MAX) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= SETTLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (changed_c) begin
            state_d = SETTLE;
        end else if (state_q == SETTLE && cnt_q == STABLE_MAX) begin
            state_d = LOCKED;
        end
    end

    // One classification strobe per stable run, on the SETTLE->LOCKED edge
    always_comb begin
        classify_c = 1'b0;
        if (state_q == SETTLE && !changed_c && cnt_q == STABLE_MAX) begin
            classify_c = 1'b1;
        end
    end

    always_comb begin
        mag_c = 4'd0;
        hit_c = 1'b1;
        case (samp_q[6:0])
            7'b0111111: mag_c = 4'd0;
            7'b0000110: mag_c = 4'd1;
            7'b1011011: mag_c = 4'd2;
            7'b1001111: mag_c = 4'd3;
            7'b1100110: mag_c = 4'd4;
            7'b1101101: mag_c = 4'd5;
            7'b1111100: mag_c = 4'd6;
            7'b0000111: mag_c = 4'd7;
            7'b1111111: mag_c = 4'd8;
            default:    hit_c = 1'b0;
        endcase
    end

    // Negative zero has no encoding, so it is treated as illegal
    always_comb begin
        kind_c  = K_ILLEGAL;
        value_c = 5'd0;
        if (samp_q[6:0] == PAT_BLANK) begin
            kind_c = K_BLANK;
        end else if (samp_q[6:0] == PAT_DASH) begin
            kind_c = K_DASH;
        end else if (hit_c && !(samp_q[7] && mag_c == 4'd0)) begin
            kind_c  = K_LEGAL;
            value_c = samp_q[7] ? 5'(5'd0 - {1'b0, mag_c}) : {1'b0, mag_c};
        end
    end

    // out_Number doubles as the last accepted legal value once have_last_q is set
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_Number   <= 5'd0;
            out_valid    <= 1'b0;
            out_range    <= 1'b0;
            out_error    <= 1'b0;
            out_errCount <= '0;
            have_last_q  <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            out_error <= 1'b0;
            if (classify_c) begin
                case (kind_c)
                    K_LEGAL: begin
                        out_range <= 1'b0;
                        if (!have_last_q || value_c != out_Number) begin
                            out_Number  <= value_c;
                            out_valid   <= 1'b1;
                            have_last_q <= 1'b1;
                        end
                    end
                    K_DASH: begin
                        out_range <= 1'b1;
                    end
                    K_ILLEGAL: begin
                        out_error <= 1'b1;
                        if (!(&out_errCount)) begin
                            out_errCount <= out_errCount + ERR_W'(1);
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_seven_seg_decoder.sv
// Randomised and directed checks of seven_seg_decoder (two parameter sets) against a
// run-length based reference model of the decode rules.
module tb_seven_seg_decoder;

    logic       clock;
    logic       reset_n;
    logic [6:0] in_Seven;
    logic       in_neg;

    logic [4:0] n0, n1;
    logic       v0, v1, r0, r1, e0, e1;
    logic [7:0] c0;
    logic [1:0] c1;

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [6:0] SEG_TAB [9] = '{
        7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
        7'b1101101, 7'b1111100, 7'b0000111, 7'b1111111
    };
    localparam logic [6:0] DASH = 7'b1000000;

    seven_seg_decoder #(.STABLE_CYCLES(4), .ERR_W(8)) dut0 (
        .clock(clock), .reset_n(reset_n), .in_Seven(in_Seven), .in_neg(in_neg),
        .out_Number(n0), .out_valid(v0), .out_range(r0), .out_error(e0),
        .out_errCount(c0)
    );

    seven_seg_decoder #(.STABLE_CYCLES(1), .ERR_W(2)) dut1 (
        .clock(clock), .reset_n(reset_n), .in_Seven(in_Seven), .in_neg(in_neg),
        .out_Number(n1), .out_valid(v1), .out_range(r1), .out_error(e1),
        .out_errCount(c1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model state, index 0 = dut0, 1 = dut1
    int         m_stable [2] = '{4, 1};
    int         m_cmax   [2] = '{255, 3};
    logic [7:0] m_prev   [2];
    int         m_run    [2];
    int         m_num    [2];
    bit         m_have   [2];
    bit         m_valid  [2];
    bit         m_range  [2];
    bit         m_error  [2];
    int         m_cnt    [2];

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int find_mag(input logic [6:0] p);
        for (int i = 0; i < 9; i++) begin
            if (SEG_TAB[i] == p) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_prev[k]  = 8'd0;
            m_run[k]   = 1;
            m_num[k]   = 0;
            m_have[k]  = 1'b0;
            m_valid[k] = 1'b0;
            m_range[k] = 1'b0;
            m_error[k] = 1'b0;
            m_cnt[k]   = 0;
        end
    endtask

    task automatic model_classify(input int k, input logic neg, input logic [6:0] p);
        int mag;
        int v;
        if (p == 7'd0) return;
        if (p == DASH) begin
            m_range[k] = 1'b1;
            return;
        end
        mag = find_mag(p);
        if (mag < 0 || (neg && mag == 0)) begin
            m_error[k] = 1'b1;
            if (m_cnt[k] < m_cmax[k]) m_cnt[k]++;
        end else begin
            v = neg ? -mag : mag;
            m_range[k] = 1'b0;
            if (!m_have[k] || v != m_num[k]) begin
                m_num[k]   = v;
                m_valid[k] = 1'b1;
                m_have[k]  = 1'b1;
            end
        end
    endtask

    // A run is classified once, when it has been sampled STABLE+1 times in a row
    task automatic model_edge(input logic neg, input logic [6:0] p);
        logic [7:0] s;
        s = {neg, p};
        for (int k = 0; k < 2; k++) begin
            m_valid[k] = 1'b0;
            m_error[k] = 1'b0;
            if (s == m_prev[k]) m_run[k]++;
            else m_run[k] = 1;
            m_prev[k] = s;
            if (m_run[k] == m_stable[k] + 1) model_classify(k, neg, p);
        end
    endtask

    task automatic check_all();
        chk("d0.number",   int'(n0), m_num[0] & 31);
        chk("d0.valid",    int'(v0), int'(m_valid[0]));
        chk("d0.range",    int'(r0), int'(m_range[0]));
        chk("d0.error",    int'(e0), int'(m_error[0]));
        chk("d0.errcount", int'(c0), m_cnt[0]);
        chk("d1.number",   int'(n1), m_num[1] & 31);
        chk("d1.valid",    int'(v1), int'(m_valid[1]));
        chk("d1.range",    int'(r1), int'(m_range[1]));
        chk("d1.error",    int'(e1), int'(m_error[1]));
        chk("d1.errcount", int'(c1), m_cnt[1]);
    endtask

    // pat is the active-high segment pattern, neg=1 means negative
    task automatic tick(input logic [6:0] pat, input logic neg);
        in_Seven = ~pat;
        in_neg   = ~neg;
        @(posedge clock);
        model_edge(neg, pat);
        #1;
        check_all();
    endtask

    task automatic hold(input logic [6:0] pat, input logic neg, input int n);
        for (int i = 0; i < n; i++) tick(pat, neg);
    endtask

    task automatic hold_digit(input int d, input logic neg, input int n);
        hold(SEG_TAB[d], neg, n);
    endtask

    // Called 1 time unit after a rising edge; pulses reset between edges
    task automatic do_reset();
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        check_all();
        #3;
        reset_n = 1'b1;
    endtask

    initial begin
        int sel;
        int len;
        logic [6:0] pat;
        logic neg;

        in_Seven = 7'h7F;
        in_neg   = 1'b1;
        reset_n  = 1'b1;
        #1;
        reset_n = 1'b0;
        model_reset();
        #1;
        check_all();
        #6;
        reset_n = 1'b1;

        hold_digit(2, 1'b0, 10);
        hold_digit(3, 1'b1, 10);
        hold_digit(8, 1'b0, 1);
        hold_digit(0, 1'b1, 10);
        hold(DASH, 1'b0, 10);
        hold_digit(4, 1'b0, 10);
        hold_digit(6, 1'b0, 10);
        hold(DASH, 1'b1, 10);
        hold_digit(6, 1'b0, 10);
        for (int i = 0; i < 4; i++) begin
            hold(7'b0000001, 1'b0, 8);
            hold(7'b0000000, 1'b0, 8);
        end
        hold_digit(8, 1'b1, 10);
        hold_digit(8, 1'b0, 10);
        hold_digit(1, 1'b0, 2);
        do_reset();
        hold_digit(0, 1'b0, 10);

        for (int seg = 0; seg < 400; seg++) begin
            sel = int'($urandom_range(0, 15));
            neg = 1'($urandom_range(0, 1));
            len = int'($urandom_range(1, 7));
            if (sel <= 8) pat = SEG_TAB[sel];
            else if (sel == 9) pat = DASH;
            else if (sel == 10) pat = 7'd0;
            else pat = 7'($urandom);
            hold(pat, neg, len);
            if ($urandom_range(0, 99) == 0) do_reset();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
